// File: rtl/dbg_disp_pkg.sv
// Shared display constants for the debug word scanner: the active-low hex glyphs,
// the blank pattern and the scan mode encoding.
package dbg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  localparam logic [6:0] HEX_GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } scan_mode_e;

endpackage

// File: rtl/hexcoder.sv
// One-digit hex to active-low seven-segment encoder.
module hexcoder
  import dbg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPHS[nibble];

endmodule

// File: rtl/dbg_word_scanner.sv
// Debug word selector with manual/auto-scan index, freeze and seven-segment output.
// Define DBG_SCAN_LZ_BLANK_EN to blank leading-zero digits.
module dbg_word_scanner
  import dbg_disp_pkg::*;
#(
  parameter  int NUM_WORDS    = 64,
  parameter  int WORD_W       = 32,
  parameter  int DWELL_CYCLES = 50_000_000,
  localparam int SEL_W        = $clog2(NUM_WORDS),
  localparam int DIGITS       = WORD_W / 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_WORDS*WORD_W-1:0] words_i,
  input  logic [SEL_W-1:0]            sel_i,
  input  logic                        mode_i,
  input  logic                        step_i,
  input  logic                        freeze_i,
  output logic [DIGITS*7-1:0]         hex_o,
  output logic [SEL_W-1:0]            cur_idx_o
);

`ifdef DBG_SCAN_LZ_BLANK_EN
  localparam bit LZ_BLANK = 1'b1;
`else
  localparam bit LZ_BLANK = 1'b0;
`endif

  localparam int BUS_W = NUM_WORDS * WORD_W;
  localparam int OFF_W = $clog2(BUS_W);
  localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(NUM_WORDS - 1);

  logic [SEL_W-1:0]    idx_q;
  logic [DW_W-1:0]     dwell_q;
  logic                step_q;
  logic [WORD_W-1:0]   disp_q;
  logic [DIGITS*7-1:0] hex_q;

  scan_mode_e        mode;
  logic              step_rise;
  logic              dwell_end;
  logic [SEL_W-1:0]  next_idx;
  logic              idx_valid;
  logic [SEL_W-1:0]  idx_safe;
  logic [OFF_W-1:0]  word_off;
  logic [WORD_W-1:0] sel_word;

  assign mode      = scan_mode_e'(mode_i);
  assign step_rise = step_i & ~step_q;
  assign dwell_end = (dwell_q == DWELL_LAST);
  // Out-of-range indices (non power-of-2 NUM_WORDS) also wrap to 0.
  assign next_idx  = (idx_q >= IDX_LAST) ? '0 : idx_q + SEL_W'(1);

  if (NUM_WORDS == (2 ** SEL_W)) begin : g_idx_full
    assign idx_valid = 1'b1;
  end else begin : g_idx_part
    assign idx_valid = (idx_q < SEL_W'(NUM_WORDS));
  end

  assign idx_safe = idx_valid ? idx_q : '0;
  assign word_off = OFF_W'(idx_safe) * OFF_W'(WORD_W);
  assign sel_word = idx_valid ? words_i[word_off +: WORD_W] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      dwell_q <= '0;
      step_q  <= 1'b0;
      disp_q  <= '0;
    end else begin
      step_q <= step_i;
      if (!freeze_i) begin
        disp_q <= sel_word;
        if (mode == MODE_MANUAL) begin
          idx_q   <= sel_i;
          dwell_q <= '0;
        end else if (step_rise || dwell_end) begin
          idx_q   <= next_idx;
          dwell_q <= '0;
        end else begin
          dwell_q <= dwell_q + DW_W'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    localparam bit         ALWAYS_SHOWN = (gi == 0) || !LZ_BLANK;
    localparam logic [6:0] SEG_RST      = ALWAYS_SHOWN ? SEG_ZERO : SEG_BLANK;

    logic [6:0] seg_raw;
    logic [6:0] seg_next;

    hexcoder u_hex (
      .nibble (disp_q[gi*4 +: 4]),
      .seg    (seg_raw)
    );

    if (ALWAYS_SHOWN) begin : g_show
      assign seg_next = seg_raw;
    end else begin : g_lz
      // Blank when this nibble and every nibble above it are zero.
      assign seg_next = (|disp_q[WORD_W-1:gi*4]) ? seg_raw : SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hex_q[gi*7 +: 7] <= SEG_RST;
      end else begin
        hex_q[gi*7 +: 7] <= seg_next;
      end
    end
  end

  assign hex_o     = hex_q;
  assign cur_idx_o = idx_q;

endmodule

// File: doc/dbg_word_scanner.md
# dbg_word_scanner

Parametrised debug-display selector for the pipelined RV32I board build. It takes a flat bus of NUM_WORDS debug words (register file, pipeline registers, PC, and similar) and picks one. In manual mode the index comes from the board switches; in auto mode it steps through all words on a dwell timer or on a push-button step. The selected word is registered and drives the active-low seven-segment digits, and a freeze control holds the displayed value.

## Interface
- NUM_WORDS, 64: number of selectable words; 2..256.
- WORD_W, 32: word width; a multiple of 4. DIGITS = WORD_W/4.
- DWELL_CYCLES, 50_000_000: auto-mode dwell per word, in clk cycles; at least 1.
- SEL_W (localparam) = $clog2(NUM_WORDS).
- clk  in  1  system clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- words_i  in  NUM_WORDS*WORD_W  flat source bus; word k is [k*WORD_W +: WORD_W].
- sel_i  in  SEL_W  manual index (switches), already synchronised.
- mode_i  in  1  0 = manual, 1 = auto-scan.
- step_i  in  1  level from a debounced button; rising edge advances the index in auto mode.
- freeze_i  in  1  level; while high, the display, index and dwell counter all hold.
- hex_o  out  DIGITS*7  segment patterns, active-low; digit d is [d*7 +: 7], and digit 0 is the least-significant nibble.
- cur_idx_o  out  SEL_W  index currently latched.

## Operation
- Registers:
  - idx_q (SEL_W)
  - dwell_q (counter 0..DWELL_CYCLES-1)
  - step_q (previous step_i)
  - disp_q (WORD_W)
  - hex_q (DIGITS*7)
- Reset values:
  - idx_q = 0, dwell_q = 0, step_q = 0, disp_q = 0.
  - hex_o shows the digit "0" on every digit (7'h40), subject to Configuration.
  - cur_idx_o = 0.
- step_rise = step_i & ~step_q. step_q updates every cycle, including during freeze.
- Priority each cycle, highest first:
  1. **freeze_i = 1:** idx_q, dwell_q and disp_q hold. A step_rise during freeze is discarded.
  2. **Manual (mode_i = 0):**
     - idx_q <= sel_i.
     - dwell_q <= 0.
  3. **Auto (mode_i = 1):**
     - If step_rise, or dwell_q == DWELL_CYCLES-1: idx_q advances and dwell_q <= 0.
     - Otherwise dwell_q increments.
     - When both advance conditions are true in the same cycle, the index advances exactly once.
- Advance rule: idx_q + 1, wrapping from NUM_WORDS-1 to 0.
- Out-of-range manual select: sel_i >= NUM_WORDS (possible when NUM_WORDS is not a power of 2) stores idx_q = sel_i. That index selects 32'h0 and cur_idx_o reports it unchanged. In auto mode, an out-of-range idx_q wraps to 0 on its next advance.
- Mode switch:
  - Manual to auto: scanning starts from the current idx_q, with dwell_q = 0.
  - Auto to manual: idx_q takes sel_i on the next edge.
- Display path:
  - When not frozen, disp_q <= words_i[idx_q].
  - hex_q <= encode(disp_q), applied per nibble.
  - Encoding is the standard hex glyph set 0-F, active-low.

## Timing
- Latency from sel_i to cur_idx_o: 1 cycle.
- Latency from sel_i to hex_o: 3 cycles (idx_q, then disp_q, then hex_q).
- A change in the selected source word appears on hex_o 2 cycles later.
- Auto dwell: the index holds for exactly DWELL_CYCLES cycles.
- step_rise to new idx_q: 1 cycle. A button held high gives one advance only.
- Freeze asserted at edge N: the disp_q captured at edge N-1 is shown from edge N+1 onward. The first edge after release resumes both sampling and counting.
- Reset asserted mid-scan: all registers clear immediately (asynchronous). After release, operation restarts from index 0.

## Configuration
- DBG_SCAN_LZ_BLANK_EN defined: leading-zero suppression.
  - Every digit above the most-significant non-zero nibble is driven 7'h7F (all segments off).
  - Digit 0 always shows, so value 0 displays as a single "0".
  - Blanking is computed in the same cycle as hex_q, so latency is unchanged.
- DBG_SCAN_LZ_BLANK_EN undefined: all DIGITS digits are always shown.

## Structure
- Package dbg_disp_pkg holds:
  - SEG_BLANK = 7'h7F
  - the 16-entry active-low glyph constant array
  - the mode enum: MODE_MANUAL = 1'b0, MODE_AUTO = 1'b1
- The existing hexcoder is used as the single sub-module, instantiated DIGITS times by a generate loop. The blanking mux sits outside hexcoder.
- The source mux is an indexed part-select on words_i, not a case statement.

## Test plan
- **Reset with words_i all 0:** hex_o = 7'h40 on every digit and cur_idx_o = 0. With the blanking macro defined, digits 7..1 are 7'h7F.
- **Manual, NUM_WORDS = 64, word 5 = 32'hDEADBEEF, sel_i 0 -> 5:** cur_idx_o = 5 after 1 cycle; hex_o digits 7..0 spell D,E,A,D,B,E,E,F (7'h21, 7'h06, ...) after 3 cycles.
- **Auto, DWELL_CYCLES = 4, NUM_WORDS = 3:** cur_idx_o sequence 0,0,0,0,1,1,1,1,2,2,2,2,0; covers the wrap from 2 to 0.
- **Auto, DWELL_CYCLES = 4, step pulse at dwell_q = 3:** a single advance (index 0 -> 1, not 2); dwell_q restarts at 0. Holding step_i high for 10 cycles gives one advance.
- **freeze_i high for 20 cycles in auto mode while word 1 changes:** hex_o and cur_idx_o stay constant. After release, counting resumes from the held dwell_q.
- **NUM_WORDS = 40, manual, sel_i = 45:** cur_idx_o = 45 and hex_o shows 0. Switch to auto: the next advance goes to 0.
